jelly2_img_timing_gen: RTL and testbench

JELLY2_IMG_TIMING_GEN -- requirements
Module: jelly2_img_timing_gen

---
 rtl/jelly2_img_pkg.sv | 14 +
 rtl/jelly2_img_timing_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_jelly2_img_timing_gen.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/jelly2_img_pkg.sv
// Shared image-pipeline definitions.
// Holds the state type used by the video timing generator.

package jelly2_img_pkg;

    // Timing generator phases: idle, visible pixels, line blanking, frame blanking
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } img_timing_state_t;

endpackage

// File: rtl/jelly2_img_timing_gen.sv
// Video frame timing generator.
// Produces a raster of width x height pixels with programmable horizontal and
// vertical blanking, emitting a registered image control bus (valid/de/flags/x/y).
// Optional feature: define JELLY2_IMG_TIMING_GEN_FRAME_COUNT_EN to add the
// m_frame_count output, a 32-bit wrapping count of frame starts.

import jelly2_img_pkg::*;

module jelly2_img_timing_gen #(
    parameter int X_BITS = 12,
    parameter int Y_BITS = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cke,
    input  logic              enable,
    input  logic [X_BITS-1:0] param_width,
    input  logic [Y_BITS-1:0] param_height,
    input  logic [X_BITS-1:0] param_h_blank,
    input  logic [Y_BITS-1:0] param_v_blank,
    output logic              busy,
    output logic              m_img_col_first,
    output logic              m_img_col_last,
    output logic              m_img_row_first,
    output logic              m_img_row_last,
    output logic              m_img_de,
    output logic              m_img_valid,
    output logic [X_BITS-1:0] m_img_x,
    output logic [Y_BITS-1:0] m_img_y
`ifdef JELLY2_IMG_TIMING_GEN_FRAME_COUNT_EN
    ,
    output logic [31:0]       m_frame_count
`endif
);

    localparam logic [X_BITS-1:0] X_ONE  = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_ONE  = Y_BITS'(1);
    localparam logic [X_BITS:0]   XW_ONE = (X_BITS + 1)'(1);

    img_timing_state_t state_q, state_d;

    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic [X_BITS-1:0] width_q, width_d;
    logic [Y_BITS-1:0] height_q, height_d;
    logic [X_BITS-1:0] hBlank_q, hBlank_d;
    logic [Y_BITS-1:0] vBlank_q, vBlank_d;
    logic [X_BITS:0]   blankCnt_q, blankCnt_d;
    logic [Y_BITS-1:0] vLine_q, vLine_d;

    logic busy_q, valid_q, de_q;
    logic colFirst_q, colLast_q, rowFirst_q, rowLast_q;
    logic busy_d, valid_d, de_d;
    logic colFirst_d, colLast_d, rowFirst_d, rowLast_d;

    logic              canStart;
    logic              frameStart;
    logic              lineDone;
    logic              frameDone;
    logic [X_BITS-1:0] widthLast;
    logic [Y_BITS-1:0] heightLast;
    logic [X_BITS:0]   hBlankLast;
    logic [X_BITS:0]   lineLenLast;

    // Raster sequencing: advance counters, pick the next phase, latch params at frame start
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        width_d    = width_q;
        height_d   = height_q;
        hBlank_d   = hBlank_q;
        vBlank_d   = vBlank_q;
        blankCnt_d = blankCnt_q;
        vLine_d    = vLine_q;
        frameStart = 1'b0;
        lineDone   = 1'b0;
        frameDone  = 1'b0;

        canStart    = enable && (param_width != '0) && (param_height != '0);
        widthLast   = width_q - X_ONE;
        heightLast  = height_q - Y_ONE;
        hBlankLast  = {1'b0, hBlank_q} - XW_ONE;
        lineLenLast = {1'b0, width_q} + {1'b0, hBlank_q} - XW_ONE;

        case (state_q)
            IDLE: begin
                frameStart = canStart;
            end
            ACTIVE: begin
                if (x_q == widthLast) begin
                    if (hBlank_q != '0) begin
                        state_d    = HBLANK;
                        blankCnt_d = '0;
                    end else begin
                        lineDone = 1'b1;
                    end
                end else begin
                    x_d = x_q + X_ONE;
                end
            end
            HBLANK: begin
                if (blankCnt_q == hBlankLast) begin
                    lineDone = 1'b1;
                end else begin
                    blankCnt_d = blankCnt_q + XW_ONE;
                end
            end
            VBLANK: begin
                if (blankCnt_q == lineLenLast) begin
                    blankCnt_d = '0;
                    if (vLine_q == vBlank_q - Y_ONE) begin
                        frameDone = 1'b1;
                    end else begin
                        vLine_d = vLine_q + Y_ONE;
                    end
                end else begin
                    blankCnt_d = blankCnt_q + XW_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (lineDone) begin
            if (y_q == heightLast) begin
                if (vBlank_q != '0) begin
                    state_d    = VBLANK;
                    blankCnt_d = '0;
                    vLine_d    = '0;
                end else begin
                    frameDone = 1'b1;
                end
            end else begin
                state_d = ACTIVE;
                x_d     = '0;
                y_d     = y_q + Y_ONE;
            end
        end

        if (frameDone) begin
            if (canStart) begin
                frameStart = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        if (frameStart) begin
            state_d  = ACTIVE;
            x_d      = '0;
            y_d      = '0;
            width_d  = param_width;
            height_d = param_height;
            hBlank_d = param_h_blank;
            vBlank_d = param_v_blank;
        end
    end

    // Output bus decoded from the next phase/coordinates so the flags are registered
    always_comb begin
        de_d       = (state_d == ACTIVE);
        valid_d    = (state_d != IDLE);
        busy_d     = (state_d != IDLE);
        colFirst_d = de_d && (x_d == '0);
        colLast_d  = de_d && (x_d == width_d - X_ONE);
        rowFirst_d = de_d && (y_d == '0);
        rowLast_d  = de_d && (y_d == height_d - Y_ONE);
    end

    // State and output registers; reset wins over cke, cke=0 freezes everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            width_q    <= '0;
            height_q   <= '0;
            hBlank_q   <= '0;
            vBlank_q   <= '0;
            blankCnt_q <= '0;
            vLine_q    <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            de_q       <= 1'b0;
            colFirst_q <= 1'b0;
            colLast_q  <= 1'b0;
            rowFirst_q <= 1'b0;
            rowLast_q  <= 1'b0;
        end else if (cke) begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            width_q    <= width_d;
            height_q   <= height_d;
            hBlank_q   <= hBlank_d;
            vBlank_q   <= vBlank_d;
            blankCnt_q <= blankCnt_d;
            vLine_q    <= vLine_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            de_q       <= de_d;
            colFirst_q <= colFirst_d;
            colLast_q  <= colLast_d;
            rowFirst_q <= rowFirst_d;
            rowLast_q  <= rowLast_d;
        end
    end

`ifdef JELLY2_IMG_TIMING_GEN_FRAME_COUNT_EN
    logic [31:0] frameCount_q;

    // Count every frame start, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            frameCount_q <= '0;
        end else if (cke && frameStart) begin
            frameCount_q <= frameCount_q + 32'd1;
        end
    end

    assign m_frame_count = frameCount_q;
`endif

    assign busy            = busy_q;
    assign m_img_valid     = valid_q;
    assign m_img_de        = de_q;
    assign m_img_col_first = colFirst_q;
    assign m_img_col_last  = colLast_q;
    assign m_img_row_first = rowFirst_q;
    assign m_img_row_last  = rowLast_q;
    assign m_img_x         = x_q;
    assign m_img_y         = y_q;

endmodule

// File: tb/tb_jelly2_img_timing_gen.sv
// Self-checking bench for jelly2_img_timing_gen.
// The reference model expands each frame into a queue of per-cycle expected
// bus values when the frame starts, then pops one entry per enabled clock.

module tb_jelly2_img_timing_gen;

    logic        clk;
    logic        reset;
    logic        cke;
    logic        enable;
    logic [11:0] param_width;
    logic [11:0] param_height;
    logic [11:0] param_h_blank;
    logic [11:0] param_v_blank;
    logic        busy;
    logic        m_img_col_first;
    logic        m_img_col_last;
    logic        m_img_row_first;
    logic        m_img_row_last;
    logic        m_img_de;
    logic        m_img_valid;
    logic [11:0] m_img_x;
    logic [11:0] m_img_y;
`ifdef JELLY2_IMG_TIMING_GEN_FRAME_COUNT_EN
    logic [31:0] m_frame_count;
`endif

    jelly2_img_timing_gen #(
        .X_BITS(12),
        .Y_BITS(12)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cke            (cke),
        .enable         (enable),
        .param_width    (param_width),
        .param_height   (param_height),
        .param_h_blank  (param_h_blank),
        .param_v_blank  (param_v_blank),
        .busy           (busy),
        .m_img_col_first(m_img_col_first),
        .m_img_col_last (m_img_col_last),
        .m_img_row_first(m_img_row_first),
        .m_img_row_last (m_img_row_last),
        .m_img_de       (m_img_de),
        .m_img_valid    (m_img_valid),
        .m_img_x        (m_img_x),
        .m_img_y        (m_img_y)
`ifdef JELLY2_IMG_TIMING_GEN_FRAME_COUNT_EN
        ,
        .m_frame_count  (m_frame_count)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        cf;
        logic        cl;
        logic        rf;
        logic        rl;
    } exp_t;

    exp_t        expQ[$];
    exp_t        cur;
    logic [31:0] expFrames;
    int          testCount;
    int          failCount;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the model and tally the outcome
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        testCount++;
        if (obs !== expv) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
        end
    endtask

    // Expand a whole frame, cycle by cycle, from its parameters
    task automatic buildFrame(input int w, input int h, input int hb, input int vb);
        exp_t e;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                e.valid = 1'b1;
                e.de    = 1'b1;
                e.x     = 12'(xx);
                e.y     = 12'(yy);
                e.cf    = (xx == 0);
                e.cl    = (xx == w - 1);
                e.rf    = (yy == 0);
                e.rl    = (yy == h - 1);
                expQ.push_back(e);
            end
            for (int b = 0; b < hb; b++) begin
                e = '0;
                e.valid = 1'b1;
                expQ.push_back(e);
            end
        end
        for (int b = 0; b < vb * (w + hb); b++) begin
            e = '0;
            e.valid = 1'b1;
            expQ.push_back(e);
        end
    endtask

    // Drive one clock of inputs, advance the model, then check the bus after the edge
    task automatic applyStimulus(input logic rst, input logic ck, input logic en,
                                 input int w, input int h, input int hb, input int vb);
        reset         = rst;
        cke           = ck;
        enable        = en;
        param_width   = 12'(w);
        param_height  = 12'(h);
        param_h_blank = 12'(hb);
        param_v_blank = 12'(vb);
        @(posedge clk);
        if (rst) begin
            expQ.delete();
            cur       = '0;
            expFrames = '0;
        end else if (ck) begin
            if (expQ.size() == 0 && en && w != 0 && h != 0) begin
                buildFrame(w, h, hb, vb);
                expFrames = expFrames + 32'd1;
            end
            if (expQ.size() != 0) cur = expQ.pop_front();
            else cur = '0;
        end
        #1;
        checkOutput("valid", {31'd0, m_img_valid}, {31'd0, cur.valid});
        checkOutput("busy", {31'd0, busy}, {31'd0, cur.valid});
        checkOutput("de", {31'd0, m_img_de}, {31'd0, cur.de});
        checkOutput("col_first", {31'd0, m_img_col_first}, {31'd0, cur.cf});
        checkOutput("col_last", {31'd0, m_img_col_last}, {31'd0, cur.cl});
        checkOutput("row_first", {31'd0, m_img_row_first}, {31'd0, cur.rf});
        checkOutput("row_last", {31'd0, m_img_row_last}, {31'd0, cur.rl});
        if (cur.de) begin
            checkOutput("x", {20'd0, m_img_x}, {20'd0, cur.x});
            checkOutput("y", {20'd0, m_img_y}, {20'd0, cur.y});
        end
`ifdef JELLY2_IMG_TIMING_GEN_FRAME_COUNT_EN
        checkOutput("frame_count", m_frame_count, expFrames);
`endif
    endtask

    // Run with enable low until the model reports idle, bounded by a cycle budget
    task automatic drainToIdle(input int budget);
        int n;
        n = 0;
        while ((cur.valid || expQ.size() != 0) && n < budget) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4, 2, 2, 1);
            n++;
        end
        checkOutput("drain_timeout", {31'd0, cur.valid}, 32'd0);
    endtask

    int rw, rh, rhb, rvb;
    logic ren;

    // Directed scenarios followed by a randomized soak and a wide-line boundary frame
    initial begin
        testCount = 0;
        failCount = 0;
        cur       = '0;
        expFrames = '0;

        // Reset, including a reset clock with cke low
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        checkOutput("rst_x", {20'd0, m_img_x}, 32'd0);
        checkOutput("rst_y", {20'd0, m_img_y}, 32'd0);

        // Zero width or height never starts a frame
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 0, 2, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 3, 0, 1, 1);

        // 4x2 frame with blanks, back-to-back frames
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4, 2, 2, 1);

        // Width change mid-frame takes effect at the next frame
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8, 2, 2, 1);

        // 1x1 frames with no blanking
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1, 1, 0, 0);
        drainToIdle(200);

        // Enable dropped on the 3rd pixel of a 4x2 frame
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4, 2, 2, 1);
        drainToIdle(200);

        // Clock enable held low for 5 cycles mid-line
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4, 2, 2, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4, 2, 2, 1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4, 2, 2, 1);
        drainToIdle(200);

        // Reset during line blanking: four pixels then one blank cycle, then reset
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4, 2, 2, 1);
        checkOutput("in_hblank", {31'd0, m_img_valid & ~m_img_de}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4, 2, 2, 1);
        checkOutput("rst_hblank_x", {20'd0, m_img_x}, 32'd0);

        // Randomized soak: small rasters, random cke, enable, parameter changes and resets
        ren = 1'b1;
        rw  = 3;
        rh  = 2;
        rhb = 1;
        rvb = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) ren = ~ren;
            if ($urandom_range(0, 39) == 0) begin
                rw  = $urandom_range(0, 6);
                rh  = $urandom_range(0, 4);
                rhb = $urandom_range(0, 3);
                rvb = $urandom_range(0, 2);
            end
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, ren, rw, rh, rhb, rvb);
        end
        drainToIdle(500);

        // Near-maximum width exercises full-width compares and the blank-line counter
        applyStimulus(1'b0, 1'b1, 1'b1, 4095, 2, 3, 1);
        for (int i = 0; i < 12400; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4095, 2, 3, 1);
        drainToIdle(100);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
